// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path (frame states and line idle level).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clr is high so every frame starts on a fresh bit boundary.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic o_bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset || clr || (cnt_reg == CNT_MAX)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign o_bit_end = !clr && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops words from a registered-read FIFO and serialises them as UART frames on o_tx.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_empty,
  output logic                  o_r_en,
  input  logic [WORD_WIDTH-1:0] i_r_data,
  input  logic                  i_enable,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_drain: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_drain: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
      $error("uart_tx_drain: PARITY_ODD must be 0 or 1");
    end
  endgenerate

  uart_tx_state_t          state_reg, state_next;
  logic [WORD_WIDTH-1:0]   shift_reg, shift_next;
  logic [IDX_W-1:0]        bit_idx_reg, bit_idx_next;
  logic                    stop_cnt_reg, stop_cnt_next;
  logic                    tx_reg, tx_next;
  logic                    bit_end;
  logic                    baud_clr;
`ifdef UART_TX_PARITY_EN
  logic                    parity_reg, parity_next;
`endif

  // The bit timer only runs once a frame is actually on the line.
  assign baud_clr = (state_reg == ST_IDLE) || (state_reg == ST_WAIT);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clr      (baud_clr),
    .o_bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      tx_reg       <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      stop_cnt_reg <= stop_cnt_next;
      tx_reg       <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  // tx_next carries the level of the bit that starts on the next cycle,
  // so o_tx stays a clean register output.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    stop_cnt_next = stop_cnt_reg;
    tx_next       = tx_reg;
    o_r_en        = 1'b0;
    o_done        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next   = parity_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        tx_next = UART_IDLE_LEVEL;
        if (i_enable && !i_empty) begin
          o_r_en     = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        shift_next = i_r_data;
`ifdef UART_TX_PARITY_EN
        parity_next = (^i_r_data) ^ 1'(PARITY_ODD);
`endif
        tx_next    = 1'b0;
        state_next = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == LAST_IDX) begin
            stop_cnt_next = 1'b0;
`ifdef UART_TX_PARITY_EN
            tx_next    = parity_reg;
            state_next = ST_PARITY;
`else
            tx_next    = UART_IDLE_LEVEL;
            state_next = ST_STOP;
`endif
          end else begin
            shift_next   = shift_reg >> 1;
            bit_idx_next = bit_idx_reg + 1'b1;
            tx_next      = shift_next[0];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          stop_cnt_next = 1'b0;
          tx_next       = UART_IDLE_LEVEL;
          state_next    = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_next = UART_IDLE_LEVEL;
        if (bit_end) begin
          if (stop_cnt_reg == LAST_STOP) begin
            o_done     = 1'b1;
            state_next = ST_IDLE;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        tx_next    = UART_IDLE_LEVEL;
        state_next = ST_IDLE;
      end
    endcase
    if (!reset) begin
      o_r_en = 1'b0;
      o_done = 1'b0;
    end
  end

  assign o_tx   = tx_reg;
  assign o_busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: FIFO model with registered read, per-cycle frame checks.
module tb_uart_tx_drain;

  localparam int W    = 8;
  localparam int C    = 4;
  localparam int SB   = 1;
  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB    = 1 + W + P + SB;
  localparam int FRAME = NB * C;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_empty;
  logic         o_r_en;
  logic [W-1:0] i_r_data;
  logic         i_enable;
  logic         o_tx;
  logic         o_busy;
  logic         o_done;

  always #5 clk = ~clk;

  uart_tx_drain #(
    .WORD_WIDTH  (W),
    .CLKS_PER_BIT(C),
    .STOP_BITS   (SB),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_empty (i_empty),
    .o_r_en  (o_r_en),
    .i_r_data(i_r_data),
    .i_enable(i_enable),
    .o_tx    (o_tx),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] fifo_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: pop on a sampled read strobe, present data the following cycle, junk otherwise.
  task automatic step();
    logic       took;
    logic [7:0] d;
    took = (o_r_en === 1'b1) && reset;
    d    = 8'h3C;
    if (took && fifo_q.size() > 0) d = fifo_q.pop_front();
    @(posedge clk);
    @(negedge clk);
    i_r_data = d;
    i_empty  = (fifo_q.size() == 0);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= W) return d[b-1];
    if (P == 1 && b == W + 1) return (^d) ^ (PODD != 0);
    return 1'b1;
  endfunction

  task automatic wait_ren(input string tag);
    for (int i = 0; i < 100 && o_r_en !== 1'b1; i++) step();
    check(tag, 32'(o_r_en), 32'd1);
  endtask

  // Called in the read-strobe cycle (cycle 0); returns in the first IDLE cycle after the frame.
  task automatic run_frame(input logic [7:0] d, input int drop_at);
    logic etx;
    check($sformatf("c0_%02h", d), {o_tx, o_busy, o_done, o_r_en}, 4'b1001);
    for (int c = 1; c <= FRAME + 1; c++) begin
      step();
      if (c == drop_at) begin
        i_enable = 1'b0;
        #1;
      end
      etx = (c < 2) ? 1'b1 : exp_bit(d, (c - 2) / C);
      check($sformatf("frame_%02h_c%0d", d, c), {o_tx, o_busy, o_done, o_r_en},
            {etx, 1'b1, (c == FRAME + 1), 1'b0});
    end
    step();
  endtask

  initial begin
    reset    = 1'b0;
    i_enable = 1'b1;
    i_r_data = 8'h3C;
    fifo_q.push_back(8'hA5);
    i_empty  = 1'b0;

    // reset held with data available: no pop, line idle
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset_%0d", i), {o_r_en, o_tx, o_busy}, 3'b010);
    end
    reset = 1'b1;
    #1;

    // single word 0xA5
    wait_ren("a5_ren");
    run_frame(8'hA5, -1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("empty_idle_%0d", i), {o_r_en, o_tx, o_busy, o_done}, 4'b0100);
      step();
    end

    // back-to-back 0x01, 0xFF: second strobe exactly FRAME+2 cycles after the first
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'hFF);
    i_empty = 1'b0;
    #1;
    wait_ren("b2b_ren");
    run_frame(8'h01, -1);
    check("b2b_period", {o_r_en, o_tx, o_busy}, 3'b110);
    run_frame(8'hFF, -1);

`ifdef UART_TX_PARITY_EN
    fifo_q.push_back(8'h07);
    i_empty = 1'b0;
    #1;
    wait_ren("par07_ren");
    run_frame(8'h07, -1);
`endif

    // enable dropped mid-frame: frame completes, no further pops until re-enabled
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    i_empty = 1'b0;
    #1;
    wait_ren("en_ren");
    run_frame(8'h11, 12);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("en_hold_%0d", i), {o_r_en, o_tx, o_busy}, 3'b010);
      step();
    end
    i_enable = 1'b1;
    #1;
    check("en_resume", 32'(o_r_en), 32'd1);
    run_frame(8'h22, -1);

    // reset during data bit 3 of 0x33, then 0x44 sent from a fresh start bit
    fifo_q.push_back(8'h44);
    check("rst_ren", 32'(o_r_en), 32'd1);
    for (int c = 1; c <= 19; c++) step();
    check("rst_pre_busy", {o_tx, o_busy}, {exp_bit(8'h33, 4), 1'b1});
    reset = 1'b0;
    #1;
    check("rst_ren_forced", 32'(o_r_en), 32'd0);
    step();
    check("rst_abort", {o_tx, o_busy, o_r_en, o_done}, 4'b1000);
    step();
    reset = 1'b1;
    #1;
    wait_ren("rst_after_ren");
    run_frame(8'h44, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
